// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - writeback arbiter: per-channel result FIFOs sharing one registered scoreboard port.
// Define FU_WB_ARB_FIXED_PRIO_EN for lowest-index-first grant instead of round-robin.
module fu_wb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_result_i,
  input  logic [NUM_REQ*TRANS_ID_BITS-1:0]  req_trans_id_i,
  input  logic [NUM_REQ-1:0]                req_ex_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_ex_cause_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [DATA_WIDTH-1:0]             wb_result_o,
  output logic [TRANS_ID_BITS-1:0]          wb_trans_id_o,
  output logic                              wb_ex_valid_o,
  output logic [DATA_WIDTH-1:0]             wb_ex_cause_o,
  output logic [$clog2(NUM_REQ)-1:0]        wb_src_o
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0]    res_q   [NUM_REQ][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    res_d   [NUM_REQ][FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q    [NUM_REQ][FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] id_d    [NUM_REQ][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    cause_q [NUM_REQ][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    cause_d [NUM_REQ][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    exv_q   [NUM_REQ];
  logic [FIFO_DEPTH-1:0]    exv_d   [NUM_REQ];
  logic [PTR_W-1:0]         wr_ptr_q [NUM_REQ];
  logic [PTR_W-1:0]         wr_ptr_d [NUM_REQ];
  logic [PTR_W-1:0]         rd_ptr_q [NUM_REQ];
  logic [PTR_W-1:0]         rd_ptr_d [NUM_REQ];
  logic [CNT_W-1:0]         cnt_q    [NUM_REQ];
  logic [CNT_W-1:0]         cnt_d    [NUM_REQ];

  logic                     wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0]    wb_result_q, wb_result_d;
  logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
  logic                     wb_exv_q, wb_exv_d;
  logic [DATA_WIDTH-1:0]    wb_cause_q, wb_cause_d;
  logic [SRC_W-1:0]         wb_src_q, wb_src_d;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
  logic [SRC_W-1:0]         rr_q, rr_d;
`endif

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   idx;
  logic               found;
  logic               load;

  // Ready looks only at the stored count so a full FIFO never relies on a same-edge pop.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      ready[k]    = cnt_q[k] < CNT_W'(FIFO_DEPTH);
      nonempty[k] = cnt_q[k] != '0;
      push[k]     = req_valid_i[k] & ready[k];
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FU_WB_ARB_FIXED_PRIO_EN
      idx = SRC_W'(i);
`else
      idx = SRC_W'((int'(rr_q) + i) % NUM_REQ);
`endif
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign load = (!wb_valid_q || wb_ready_i) && found;

  always_comb begin
    res_d       = res_q;
    id_d        = id_q;
    cause_d     = cause_q;
    exv_d       = exv_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_id_d     = wb_id_q;
    wb_exv_d    = wb_exv_q;
    wb_cause_d  = wb_cause_q;
    wb_src_d    = wb_src_q;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    if (flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        cnt_d[k]    = '0;
      end
      wb_valid_d = 1'b0;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
      rr_d       = '0;
`endif
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (push[k]) begin
          res_d[k][wr_ptr_q[k]]   = req_result_i[k*DATA_WIDTH +: DATA_WIDTH];
          id_d[k][wr_ptr_q[k]]    = req_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
          cause_d[k][wr_ptr_q[k]] = req_ex_cause_i[k*DATA_WIDTH +: DATA_WIDTH];
          exv_d[k][wr_ptr_q[k]]   = req_ex_valid_i[k];
          wr_ptr_d[k]             = wr_ptr_q[k] + 1'b1;
        end
        if (load && grant == SRC_W'(k)) begin
          rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
        end
        cnt_d[k] = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(load && grant == SRC_W'(k));
      end
      if (load) begin
        wb_valid_d  = 1'b1;
        wb_result_d = res_q[grant][rd_ptr_q[grant]];
        wb_id_d     = id_q[grant][rd_ptr_q[grant]];
        wb_cause_d  = cause_q[grant][rd_ptr_q[grant]];
        wb_exv_d    = exv_q[grant][rd_ptr_q[grant]];
        wb_src_d    = grant;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
        rr_d        = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`endif
      end else if (!wb_valid_q || wb_ready_i) begin
        wb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_id_q     <= '0;
      wb_exv_q    <= 1'b0;
      wb_cause_q  <= '0;
      wb_src_q    <= '0;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_id_q     <= wb_id_d;
      wb_exv_q    <= wb_exv_d;
      wb_cause_q  <= wb_cause_d;
      wb_src_q    <= wb_src_d;
`ifndef FU_WB_ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Entry storage is only meaningful below the count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    res_q   <= res_d;
    id_q    <= id_d;
    cause_q <= cause_d;
    exv_q   <= exv_d;
  end

  assign req_ready_o   = ready;
  assign wb_valid_o    = wb_valid_q;
  assign wb_result_o   = wb_result_q;
  assign wb_trans_id_o = wb_id_q;
  assign wb_ex_valid_o = wb_exv_q;
  assign wb_ex_cause_o = wb_cause_q;
  assign wb_src_o      = wb_src_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb/tb_fu_wb_arbiter.sv - scoreboard bench for fu_wb_arbiter against a queue-based reference model.
module tb_fu_wb_arbiter;
  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int IW    = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, wb_ready;
  logic [N-1:0]    req_valid, req_ready, req_exv;
  logic [N*DW-1:0] req_result, req_cause;
  logic [N*IW-1:0] req_id;
  logic            wb_valid, wb_exv;
  logic [DW-1:0]   wb_result, wb_cause;
  logic [IW-1:0]   wb_id;
  logic [1:0]      wb_src;

  fu_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TRANS_ID_BITS(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_result_i(req_result),
    .req_trans_id_i(req_id), .req_ex_valid_i(req_exv), .req_ex_cause_i(req_cause),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
    .wb_trans_id_o(wb_id), .wb_ex_valid_o(wb_exv), .wb_ex_cause_o(wb_cause), .wb_src_o(wb_src)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [IW-1:0] id;
    logic          exv;
    logic [DW-1:0] cause;
    int            src;
  } item_t;

  item_t chq [N][$];
  item_t expq [$];
  logic  m_valid;
  int    rr;
  int    vectors, miscompares;
  bit    checks_on;

  logic [DW-1:0] d_res [N];
  logic [IW-1:0] d_id [N];
  logic          d_exv [N];
  logic [DW-1:0] d_cause [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      d_res[k]   = {$urandom, $urandom};
      d_id[k]    = IW'($urandom);
      d_exv[k]   = 1'($urandom);
      d_cause[k] = {$urandom, $urandom};
    end
  endtask

  // Reference: one edge of the arbiter expressed as queue operations.
  task automatic model_edge(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rs);
    logic [N-1:0] acc;
    int g;
    int c;
    item_t it;
    if (rs) begin
      for (int k = 0; k < N; k++) chq[k].delete();
      expq.delete();
      m_valid = 1'b0;
      rr = 0;
      return;
    end
    if (fl) begin
      if (m_valid && !rdy && expq.size() > 0) void'(expq.pop_back());
      for (int k = 0; k < N; k++) chq[k].delete();
      m_valid = 1'b0;
      rr = 0;
      return;
    end
    for (int k = 0; k < N; k++) acc[k] = v[k] && (chq[k].size() < DEPTH);
    if (!m_valid || rdy) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
`ifdef FU_WB_ARB_FIXED_PRIO_EN
        c = i;
`else
        c = (rr + i) % N;
`endif
        if (g < 0 && chq[c].size() > 0) g = c;
      end
      if (g >= 0) begin
        it = chq[g].pop_front();
        it.src = g;
        expq.push_back(it);
        m_valid = 1'b1;
        rr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        it.res = d_res[k]; it.id = d_id[k]; it.exv = d_exv[k]; it.cause = d_cause[k]; it.src = k;
        chq[k].push_back(it);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rs);
    rst = rs; flush = fl; wb_ready = rdy; req_valid = v;
    for (int k = 0; k < N; k++) begin
      req_result[k*DW +: DW] = d_res[k];
      req_id[k*IW +: IW]     = d_id[k];
      req_exv[k]             = d_exv[k];
      req_cause[k*DW +: DW]  = d_cause[k];
    end
    if (checks_on) begin
      for (int k = 0; k < N; k++)
        chk($sformatf("req_ready[%0d]", k), 64'(req_ready[k]), 64'(chq[k].size() < DEPTH));
      chk("wb_valid", 64'(wb_valid), 64'(m_valid));
    end
    @(posedge clk);
    model_edge(v, rdy, fl, rs);
    @(negedge clk);
    if (rs) begin
      checks_on = 1'b1;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_result", wb_result, 64'd0);
      chk("rst_wb_id", 64'(wb_id), 64'd0);
      chk("rst_wb_exv", 64'(wb_exv), 64'd0);
      chk("rst_wb_cause", wb_cause, 64'd0);
      chk("rst_wb_src", 64'(wb_src), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'hF);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_data();
      step('0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Monitor: the head of the scoreboard must be on the port whenever valid is shown.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (checks_on && wb_valid === 1'b1) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wb_spurious: got valid=1 id=%0h expected no writeback", wb_id);
        end else begin
          e = expq[0];
          chk("wb_result", wb_result, e.res);
          chk("wb_trans_id", 64'(wb_id), 64'(e.id));
          chk("wb_ex_valid", 64'(wb_exv), 64'(e.exv));
          chk("wb_ex_cause", wb_cause, e.cause);
          chk("wb_src", 64'(wb_src), 64'(e.src));
          if (wb_ready) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    logic rdy, fl, rs;
    vectors = 0; miscompares = 0; checks_on = 1'b0;
    m_valid = 1'b0; rr = 0;
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; req_valid = '0;
    req_result = '0; req_id = '0; req_exv = '0; req_cause = '0;
    rand_data();
    @(negedge clk);
    step('0, 1'b0, 1'b0, 1'b1);

    // single push on channel 1
    rand_data(); d_res[1] = 64'hDEAD; d_id[1] = 3'd5;
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    idle(3);

    // four-way collision
    rand_data();
    for (int k = 0; k < N; k++) d_id[k] = IW'(k);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    idle(6);

    // fairness between channels 0 and 2
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step(4'b0101, 1'b1, 1'b0, 1'b0);
    end
    idle(6);

    // backpressure on channel 3
    for (int i = 0; i < 4; i++) begin
      rand_data(); d_id[3] = IW'(i + 1);
      step(4'b1000, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step('0, 1'b0, 1'b0, 1'b0);
    end
    idle(6);

    // flush with buffered entries and a same-edge push
    rand_data();
    step(4'b1110, 1'b0, 1'b0, 1'b0);
    rand_data();
    step('0, 1'b0, 1'b0, 1'b0);
    rand_data();
    step(4'b0001, 1'b0, 1'b1, 1'b0);
    idle(4);

    // reset mid-operation, then single push again
    rand_data();
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    rand_data();
    step('0, 1'b0, 1'b0, 1'b0);
    rand_data();
    step('0, 1'b0, 1'b0, 1'b1);
    rand_data(); d_res[1] = 64'hDEAD; d_id[1] = 3'd5;
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      v   = N'($urandom);
      rdy = ($urandom % 4) != 0;
      fl  = ($urandom % 50) == 0;
      rs  = ($urandom % 300) == 0;
      if (rs) rdy = 1'b0;
      step(v, rdy, fl, rs);
    end
    idle(12);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
